// File: rtl/nibble_serial_alu_pkg.sv
// Shared constants and types for the nibble-serial word ALU.
// Optional signed-flag logic is enabled by defining FLAGS_EN.
package nibble_serial_alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_INCA  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       carry;
    } req_ctl_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INCA);
    endfunction

    function automatic logic init_carry(input logic [2:0] op, input logic cin);
        case (op)
            OP_ADD:  return cin;
            OP_SUB:  return 1'b1;
            OP_INCA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nibble_serial_alu_slice.sv
// Combinational 4-bit ALU slice; c3 (carry into the top bit) exists only
// when FLAGS_EN is defined, since it feeds nothing but the overflow flag.
module nibble_slice
    import nibble_serial_alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic [2:0]          op,
    input  logic                ci,
`ifdef FLAGS_EN
    output logic                c3,
`endif
    output logic [NIBBLE_W-1:0] f4,
    output logic                co
);

    logic [NIBBLE_W-1:0] bb;
    logic [NIBBLE_W:0]   sum;

    // INCA is a + 0 + 1: the operand is gated off and the initial carry supplies the 1.
    always_comb begin
        bb = '0;
        case (op)
            OP_ADD:  bb = b4;
            OP_SUB:  bb = ~b4;
            default: bb = '0;
        endcase
    end

    assign sum = {1'b0, a4} + {1'b0, bb} + {{NIBBLE_W{1'b0}}, ci};

`ifdef FLAGS_EN
    logic [NIBBLE_W-1:0] low;
    assign low = {1'b0, a4[NIBBLE_W-2:0]} + {1'b0, bb[NIBBLE_W-2:0]}
               + {{(NIBBLE_W-1){1'b0}}, ci};
    assign c3  = is_arith(op) ? low[NIBBLE_W-1] : 1'b0;
`endif

    always_comb begin
        f4 = '0;
        co = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INCA: begin
                f4 = sum[NIBBLE_W-1:0];
                co = sum[NIBBLE_W];
            end
            OP_AND:   f4 = a4 & b4;
            OP_OR:    f4 = a4 | b4;
            OP_XOR:   f4 = a4 ^ b4;
            OP_NOTA:  f4 = ~a4;
            OP_PASSB: f4 = b4;
            default:  f4 = '0;
        endcase
    end

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-cycle word ALU: one nibble per clock, LSB first, carry registered between slices.
// Define FLAGS_EN to compute the ovf/neg flags; otherwise they are tied low.
module nibble_serial_alu
    import nibble_serial_alu_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIBBLE_W * NIBBLES,
    localparam int IDX_W  = $clog2(NIBBLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         ovf,
    output logic         neg
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q, b_q, result_q, res_n;
    req_ctl_t           ctl_q;
    logic               cout_q, zero_q;
    logic [NIBBLE_W-1:0] a4, b4, f4;
    logic               co;
    logic               last;

    assign last = (idx == IDX_W'(NIBBLES - 1));
    assign a4   = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b4   = b_q[idx*NIBBLE_W +: NIBBLE_W];

`ifdef FLAGS_EN
    logic c3;
    logic ovf_q, neg_q;
`endif

    nibble_slice u_slice (
        .a4 (a4),
        .b4 (b4),
        .op (ctl_q.op),
        .ci (ctl_q.carry),
`ifdef FLAGS_EN
        .c3 (c3),
`endif
        .f4 (f4),
        .co (co)
    );

    // Current slice merged into the word so zero can see all W bits on the last nibble.
    always_comb begin
        res_n = result_q;
        res_n[idx*NIBBLE_W +: NIBBLE_W] = f4;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef FLAGS_EN
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q         <= a;
                        b_q         <= b;
                        ctl_q.op    <= op;
                        ctl_q.carry <= init_carry(op, cin);
                        idx         <= '0;
                    end
                end
                ST_RUN: begin
                    result_q    <= res_n;
                    ctl_q.carry <= co;
                    idx         <= idx + 1'b1;
                    if (last) begin
                        idx    <= '0;
                        cout_q <= is_arith(ctl_q.op) ? co : 1'b0;
                        zero_q <= (res_n == '0);
`ifdef FLAGS_EN
                        ovf_q  <= is_arith(ctl_q.op) ? (c3 ^ co) : 1'b0;
                        neg_q  <= f4[NIBBLE_W-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef FLAGS_EN
    assign ovf    = ovf_q;
    assign neg    = neg_q;
`else
    assign ovf    = 1'b0;
    assign neg    = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed self-checking bench for nibble_serial_alu (NIBBLES=4, W=16).
module tb_nibble_serial_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        cout, zero, ovf, neg;

    int total = 0;
    int pass  = 0;
    int fails = 0;

    nibble_serial_alu #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic ci, output logic [15:0] r, output logic [3:0] fl,
                         output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        op = o; a = aa; b = bb; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble operands after acceptance; they must not matter
        a = 16'($urandom); b = 16'($urandom); cin = ~ci; op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        r  = result;
        fl = {cout, zero, ovf, neg};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // flags expected: {cout, zero, ovf, neg}; ovf/neg given for the FLAGS_EN build
    task automatic run(input string tag, input logic [2:0] o, input logic [15:0] aa,
                       input logic [15:0] bb, input logic ci, input logic [15:0] er,
                       input logic eco, input logic ez, input logic ev, input logic en);
        logic [15:0] r;
        logic [3:0]  fl;
        int          lat;
        logic [3:0]  efl;
`ifdef FLAGS_EN
        efl = {eco, ez, ev, en};
`else
        efl = {eco, ez, 2'b00};
`endif
        do_op(o, aa, bb, ci, r, fl, lat);
        chk({tag, ".latency"}, lat, 5);
        chk({tag, ".result"}, {16'h0, r}, {16'h0, er});
        chk({tag, ".flags"}, {28'h0, fl}, {28'h0, efl});
    endtask

    initial begin
        logic [15:0] hold_r;
        logic [3:0]  hold_f;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 16'h0; b = 16'h0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready_valid", {30'h0, in_ready, out_valid}, 32'h2);
        chk("reset.result", {16'h0, result}, 32'h0);
        chk("reset.flags", {28'h0, cout, zero, ovf, neg}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("add_carry_nib", 3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        run("add_wrap",      3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sub_borrow",    3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run("sub_equal",     3'd1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("add_cin",       3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        run("and",           3'd2, 16'hA5C3, 16'h0FF0, 1'b0, 16'h05C0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("or",            3'd3, 16'hA5C3, 16'h0FF0, 1'b0, 16'hAFF3, 1'b0, 1'b0, 1'b0, 1'b1);
        run("xor",           3'd4, 16'hA5C3, 16'h0FF0, 1'b0, 16'hAA33, 1'b0, 1'b0, 1'b0, 1'b1);
        run("nota",          3'd5, 16'hA5C3, 16'h0FF0, 1'b0, 16'h5A3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run("passb",         3'd7, 16'hA5C3, 16'h0FF0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("passb_zero",    3'd7, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run("inca_ovf",      3'd6, 16'h7FFF, 16'h1234, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        run("add_ovf",       3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        run("sub_ovf",       3'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // backpressure: DONE must hold with out_ready low, ignoring in_valid
        op = 3'd0; a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp.latency", lat, 5);
        hold_r = result;
        hold_f = {cout, zero, ovf, neg};
        op = 3'd7; b = 16'hBEEF; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp.hold", {10'h0, out_valid, in_ready, hold_f, result},
                {10'h0, 1'b1, 1'b0, 4'b0000, 16'h0100});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.release", {30'h0, out_valid, in_ready}, 32'h1);
        chk("bp.held_value", {16'h0, hold_r}, 32'h0100);

        // reset on the second RUN cycle discards the word
        op = 3'd0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.ready_valid", {30'h0, in_ready, out_valid}, 32'h2);
        chk("midrst.result", {16'h0, result}, 32'h0);
        chk("midrst.flags", {28'h0, cout, zero, ovf, neg}, 32'h0);
        run("after_rst_add", 3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
